// File: rtl/sata_oob_pkg.sv
// SATA host OOB sequencer: shared state encodings,
// default timing constants and registered-output decode.
package sata_oob_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_COMRESET     = 4'd1,
    ST_WAIT_COMINIT = 4'd2,
    ST_COMWAKE      = 4'd3,
    ST_WAIT_COMWAKE = 4'd4,
    ST_SEND_D102    = 4'd5,
    ST_SEND_ALIGN   = 4'd6,
    ST_READY        = 4'd7,
    ST_ERROR        = 4'd8
  } state_t;

  localparam int         DEF_LGTIMEOUT       = 20;
  localparam logic [19:0] DEF_COMINIT_TIMEOUT = 20'd132000;
  localparam logic [19:0] DEF_ALIGN_TIMEOUT   = 20'd131000;
  localparam logic [3:0]  DEF_MAX_RETRIES     = 4'd8;
  localparam logic [1:0]  DEF_NONALIGN_COUNT  = 2'd3;

  typedef struct packed {
    logic first;
    logic comreset;
    logic comwake;
    logic elecidle;
    logic d102;
    logic align;
    logic link_up;
    logic err;
  } outs_t;

  // Output bundle loaded on entry to state s; 'first'
  // marks the entry cycle and restarts the wait timer.
  function automatic outs_t state_outs(state_t s);
    outs_t o;
    o          = '0;
    o.first    = 1'b1;
    o.comreset = (s == ST_COMRESET);
    o.comwake  = (s == ST_COMWAKE);
    o.elecidle = !(s inside {ST_SEND_D102,
                             ST_SEND_ALIGN,
                             ST_READY});
    o.d102     = (s == ST_SEND_D102);
    o.align    = (s == ST_SEND_ALIGN);
    o.link_up  = (s == ST_READY);
    o.err      = (s == ST_ERROR);
    return o;
  endfunction

endpackage

// File: rtl/sata_oob_ctrl_timer.sv
// Shared wait timer: saturating up-counter cleared on
// state entry, with a terminal-count compare.
module sata_oob_timer #(
  parameter int LGTIMEOUT = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 clr,
  input  logic [LGTIMEOUT-1:0] limit,
  output logic                 done
);

  logic [LGTIMEOUT-1:0] cnt;
  logic [LGTIMEOUT-1:0] value;

  // The clear cycle reads as zero, so the register
  // already holds one for the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      cnt <= '0;
    else if (clr)
      cnt <= LGTIMEOUT'(1);
    else if (cnt != '1)
      cnt <= cnt + LGTIMEOUT'(1);
  end

  assign value = clr ? '0 : cnt;
  assign done  = (value == limit);

endmodule

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB bring-up: COMRESET, COMINIT,
// COMWAKE, D10.2/ALIGN negotiation, retry and error.
module sata_oob_ctrl
  import sata_oob_pkg::*;
#(
  parameter int LGTIMEOUT = DEF_LGTIMEOUT,
  parameter logic [LGTIMEOUT-1:0] COMINIT_TIMEOUT =
    DEF_COMINIT_TIMEOUT,
  parameter logic [LGTIMEOUT-1:0] ALIGN_TIMEOUT =
    DEF_ALIGN_TIMEOUT,
  parameter logic [3:0] MAX_RETRIES = DEF_MAX_RETRIES,
  parameter logic [1:0] NONALIGN_COUNT =
    DEF_NONALIGN_COUNT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_phy_ready,
  input  logic       i_restart,
  output logic       o_tx_comreset,
  output logic       o_tx_comwake,
  input  logic       i_tx_comfinish,
  output logic       o_tx_elecidle,
  input  logic       i_rx_cominit,
  input  logic       i_rx_comwake,
  input  logic       i_rx_valid,
  input  logic       i_rx_align,
  input  logic       i_rx_prim,
  output logic       o_tx_d102,
  output logic       o_tx_align,
  output logic       o_link_up,
  output logic       o_err,
  output logic [3:0] o_state
);

  state_t               state;
  outs_t                q;
  logic [3:0]           retries;
  logic [1:0]           na_cnt;
  logic                 tmr_done;
  logic [LGTIMEOUT-1:0] tmr_limit;
  state_t               retry_st;
  logic                 align_ev;
  logic                 prim_ev;
  logic                 na_hit;

  assign align_ev = i_rx_valid && i_rx_align;
  assign prim_ev  = i_rx_valid && i_rx_prim
                    && !i_rx_align;
  assign na_hit   = prim_ev
                    && (na_cnt == NONALIGN_COUNT - 2'd1);
  assign retry_st = (retries < MAX_RETRIES)
                    ? ST_COMRESET : ST_ERROR;
  assign tmr_limit =
    (state == ST_SEND_D102 || state == ST_SEND_ALIGN)
    ? ALIGN_TIMEOUT - LGTIMEOUT'(1)
    : COMINIT_TIMEOUT - LGTIMEOUT'(1);

  sata_oob_timer #(
    .LGTIMEOUT(LGTIMEOUT)
  ) u_timer (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .clr    (q.first),
    .limit  (tmr_limit),
    .done   (tmr_done)
  );

  // Sequencer: state plus outputs decoded from the
  // state being entered, so every output is a flop.
  always_ff @(posedge i_clk) begin
    q.first    <= 1'b0;
    q.comreset <= 1'b0;
    q.comwake  <= 1'b0;
    if (state != ST_SEND_ALIGN)
      na_cnt <= '0;
    if (i_reset) begin
      state   <= ST_IDLE;
      q       <= state_outs(ST_IDLE);
      retries <= '0;
      na_cnt  <= '0;
    end else if (!i_phy_ready) begin
      state   <= ST_IDLE;
      q       <= state_outs(ST_IDLE);
      retries <= '0;
    end else if (i_restart) begin
      state   <= ST_COMRESET;
      q       <= state_outs(ST_COMRESET);
      retries <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!q.err) begin
            state <= ST_COMRESET;
            q     <= state_outs(ST_COMRESET);
          end
        end
        ST_COMRESET: begin
          if (i_tx_comfinish && !q.comreset) begin
            state   <= ST_WAIT_COMINIT;
            q       <= state_outs(ST_WAIT_COMINIT);
            retries <= retries + 4'd1;
          end
        end
        ST_WAIT_COMINIT: begin
          if (i_rx_cominit) begin
            state <= ST_COMWAKE;
            q     <= state_outs(ST_COMWAKE);
          end else if (tmr_done) begin
            state <= retry_st;
            q     <= state_outs(retry_st);
          end
        end
        ST_COMWAKE: begin
          if (i_tx_comfinish && !q.comwake) begin
            state <= ST_WAIT_COMWAKE;
            q     <= state_outs(ST_WAIT_COMWAKE);
          end
        end
        ST_WAIT_COMWAKE: begin
          if (i_rx_comwake) begin
            state <= ST_SEND_D102;
            q     <= state_outs(ST_SEND_D102);
          end else if (tmr_done) begin
            state <= retry_st;
            q     <= state_outs(retry_st);
          end
        end
        ST_SEND_D102: begin
          if (align_ev) begin
            state <= ST_SEND_ALIGN;
            q     <= state_outs(ST_SEND_ALIGN);
          end else if (tmr_done) begin
            state <= retry_st;
            q     <= state_outs(retry_st);
          end
        end
        ST_SEND_ALIGN: begin
          if (na_hit) begin
            state <= ST_READY;
            q     <= state_outs(ST_READY);
          end else if (tmr_done) begin
            state <= retry_st;
            q     <= state_outs(retry_st);
          end else if (align_ev) begin
            na_cnt <= '0;
          end else if (prim_ev) begin
            na_cnt <= na_cnt + 2'd1;
          end
        end
        ST_READY: begin
          retries <= '0;
          if (i_rx_cominit) begin
            state <= ST_COMWAKE;
            q     <= state_outs(ST_COMWAKE);
          end
        end
        ST_ERROR: begin
        end
        default: begin
          state <= ST_IDLE;
          q     <= state_outs(ST_IDLE);
        end
      endcase
    end
  end

  assign o_tx_comreset = q.comreset;
  assign o_tx_comwake  = q.comwake;
  assign o_tx_elecidle = q.elecidle;
  assign o_tx_d102     = q.d102;
  assign o_tx_align    = q.align;
  assign o_link_up     = q.link_up;
  assign o_err         = q.err;
  assign o_state       = state;

endmodule
